// File: rtl/count_step_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_step_scheduler_if : step requests in, count and status out  (rev 1.0)
// ---------------------------------------------------------------------------
interface count_step_scheduler_if #(
  parameter int WIDTH = 4
);
  logic             man_en;
  logic             man_up;
  logic             auto_mode;
  logic             auto_up;
  logic             tick;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             at_min;
  logic             at_max;
  logic [1:0]       mode;

  modport master (
    output man_en, man_up, auto_mode, auto_up, tick, clear,
    input  count, step, at_min, at_max, mode
  );

  modport slave (
    input  man_en, man_up, auto_mode, auto_up, tick, clear,
    output count, step, at_min, at_max, mode
  );
endinterface
`default_nettype wire

// File: rtl/count_step_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_step_scheduler : arbitrates manual/auto steps of a range-limited
// up/down display counter                                          (rev 1.0)
// ---------------------------------------------------------------------------
module count_step_scheduler #(
  parameter int WIDTH       = 4,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 9,
  parameter int WRAP        = 1,
  parameter int PAUSE_TICKS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  count_step_scheduler_if.slave        bus
);

  localparam int PW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
  localparam logic [WIDTH-1:0] C_MIN        = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] C_MAX        = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_SPAN       = WIDTH'(MAX_VAL - MIN_VAL);
  localparam logic [PW-1:0]    C_PAUSE_LAST = PW'(PAUSE_TICKS - 1);

  typedef enum logic [1:0] {
    S_MANUAL  = 2'b00,
    S_AUTO    = 2'b01,
    S_PAUSE   = 2'b10,
    S_ILLEGAL = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pause_q, pause_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;

  logic             w_man_acc;
  logic             w_tick_acc;
  logic             w_dir_up;
  logic             w_in_range;
  logic [WIDTH-1:0] w_stepped;

  // Offset compare folds both range bounds into one unsigned test.
  always_comb begin
    w_man_acc  = bus.man_en & ~bus.clear;
    w_tick_acc = bus.tick & ~bus.clear & ~bus.man_en & bus.auto_mode &
                 (state_q == S_AUTO);
    w_dir_up   = w_man_acc ? bus.man_up : bus.auto_up;
    w_in_range = ((count_q - C_MIN) <= C_SPAN);

    w_stepped = count_q;
    if (!w_in_range) begin
      w_stepped = C_MIN;
    end else if (w_dir_up) begin
      if (count_q == C_MAX) w_stepped = (WRAP != 0) ? C_MIN : C_MAX;
      else                  w_stepped = count_q + 1'b1;
    end else begin
      if (count_q == C_MIN) w_stepped = (WRAP != 0) ? C_MAX : C_MIN;
      else                  w_stepped = count_q - 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    if (bus.clear) begin
      count_d = C_MIN;
      step_d  = (count_q != C_MIN);
    end else if (w_man_acc || w_tick_acc) begin
      count_d = w_stepped;
      step_d  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    case (state_q)
      S_MANUAL: begin
        if (bus.auto_mode) state_d = S_AUTO;
      end
      S_AUTO: begin
        if (!bus.auto_mode) begin
          state_d = S_MANUAL;
        end else if (w_man_acc) begin
          state_d = S_PAUSE;
          pause_d = '0;
        end
      end
      S_PAUSE: begin
        if (!bus.auto_mode) begin
          state_d = S_MANUAL;
          pause_d = '0;
        end else if (bus.man_en) begin
          pause_d = '0;
        end else if (bus.tick) begin
          if (pause_q == C_PAUSE_LAST) begin
            state_d = S_AUTO;
            pause_d = '0;
          end else begin
            pause_d = pause_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_MANUAL;
        pause_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_MANUAL;
      pause_q <= '0;
      count_q <= C_MIN;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.step   = step_q;
  assign bus.at_min = (count_q == C_MIN);
  assign bus.at_max = (count_q == C_MAX);
  assign bus.mode   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_count_step_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_count_step_scheduler : directed checks of a wrapping and a saturating
// counter instance                                                 (rev 1.0)
// ---------------------------------------------------------------------------
module tb_count_step_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  count_step_scheduler_if #(.WIDTH(4)) if1 ();
  count_step_scheduler_if #(.WIDTH(4)) if0 ();

  count_step_scheduler #(
    .WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .WRAP(1), .PAUSE_TICKS(3)
  ) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  count_step_scheduler #(
    .WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .WRAP(0), .PAUSE_TICKS(3)
  ) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic man(input logic up);
    if1.man_en = 1'b1;
    if1.man_up = up;
    cyc();
    if1.man_en = 1'b0;
  endtask

  task automatic tk();
    if1.tick = 1'b1;
    cyc();
    if1.tick = 1'b0;
  endtask

  initial begin
    if1.man_en = 0; if1.man_up = 0; if1.auto_mode = 0;
    if1.auto_up = 0; if1.tick = 0; if1.clear = 0;
    if0.man_en = 0; if0.man_up = 0; if0.auto_mode = 0;
    if0.auto_up = 0; if0.tick = 0; if0.clear = 0;

    #12;
    chk("rst_count",  if1.count,  0);
    chk("rst_step",   if1.step,   0);
    chk("rst_at_min", if1.at_min, 1);
    chk("rst_at_max", if1.at_max, 0);
    chk("rst_mode",   if1.mode,   0);
    reset = 1'b0;
    cyc();
    chk("release_no_step", if1.step, 0);

    // Ten up steps wrap 0..9 back to 0.
    for (int i = 1; i <= 10; i++) begin
      man(1'b1);
      chk("up_count",  if1.count,  i % 10);
      chk("up_step",   if1.step,   1);
      chk("up_at_max", if1.at_max, (i % 10) == 9);
      cyc();
      chk("up_step_one_cycle", if1.step, 0);
    end
    man(1'b0);
    chk("down_wrap_count", if1.count, 9);
    man(1'b1);
    chk("up_wrap_count", if1.count, 0);

    // Saturating instance: down at minimum holds but still pulses step.
    if0.man_en = 1'b1; if0.man_up = 1'b0;
    cyc();
    if0.man_en = 1'b0;
    chk("sat_count",  if0.count,  0);
    chk("sat_step",   if0.step,   1);
    chk("sat_at_min", if0.at_min, 1);
    cyc();
    chk("sat_step_clr", if0.step, 0);

    // Auto-run.
    if1.auto_mode = 1'b1; if1.auto_up = 1'b1;
    cyc();
    chk("auto_mode", if1.mode, 1);
    chk("auto_count_idle", if1.count, 0);
    tk();
    chk("tick1_count", if1.count, 1);
    chk("tick1_step",  if1.step,  1);
    cyc(); cyc(); cyc();
    chk("tick_idle_count", if1.count, 1);
    tk();
    chk("tick2_count", if1.count, 2);
    if1.tick = 1'b1;
    man(1'b0);
    if1.tick = 1'b0;
    chk("override_count", if1.count, 1);
    chk("override_mode",  if1.mode,  2);
    chk("override_step",  if1.step,  1);

    // Pause: two ticks, a manual step restarts the wait, then three ticks.
    tk();
    chk("pause_t1_mode",  if1.mode,  2);
    chk("pause_t1_count", if1.count, 1);
    chk("pause_t1_step",  if1.step,  0);
    cyc();
    tk();
    chk("pause_t2_mode", if1.mode, 2);
    man(1'b1);
    chk("pause_man_count", if1.count, 2);
    chk("pause_man_mode",  if1.mode,  2);
    tk();
    tk();
    chk("pause_restart_mode", if1.mode, 2);
    tk();
    chk("resume_mode",  if1.mode,  1);
    chk("resume_count", if1.count, 2);
    chk("resume_step",  if1.step,  0);
    tk();
    chk("resumed_tick_count", if1.count, 3);

    // auto_mode dropping drops a same-cycle tick.
    if1.auto_mode = 1'b0;
    tk();
    chk("auto_off_mode",  if1.mode,  0);
    chk("auto_off_count", if1.count, 3);
    chk("auto_off_step",  if1.step,  0);
    if1.auto_mode = 1'b1;
    cyc();
    chk("auto_on_mode", if1.mode, 1);

    // Clear beats man_en and tick.
    man(1'b1);
    man(1'b1);
    chk("pre_clear_count", if1.count, 5);
    if1.clear = 1'b1; if1.man_en = 1'b1; if1.tick = 1'b1;
    cyc();
    if1.clear = 1'b0; if1.man_en = 1'b0; if1.tick = 1'b0;
    chk("clear_count", if1.count, 0);
    chk("clear_step",  if1.step,  1);
    cyc();
    chk("clear_step_one", if1.step, 0);
    if1.clear = 1'b1;
    cyc();
    if1.clear = 1'b0;
    chk("clear_at_min_count", if1.count, 0);
    chk("clear_at_min_step",  if1.step,  0);

    // Reach count=7 in auto mode, then reset asynchronously mid-cycle.
    for (int i = 0; i < 6; i++) man(1'b1);
    tk(); tk(); tk();
    chk("pre_rst_mode", if1.mode, 1);
    tk();
    chk("pre_rst_count", if1.count, 7);
    chk("pre_rst_step",  if1.step,  1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", if1.count, 0);
    chk("async_rst_mode",  if1.mode,  0);
    chk("async_rst_step",  if1.step,  0);
    chk("async_rst_at_min", if1.at_min, 1);
    cyc();
    reset = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
